// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit.
//   size_e  : access-size encoding as it arrives on req_size (2'b11 folds to word)
//   state_e : LSU control FSM states
// Helpers decode the raw size field, compute the lane offset actually used on the
// bus and detect naturally-misaligned accesses.
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_e;

  // 2'b11 is an unused encoding and behaves as a word access.
  function automatic size_e decode_size(input logic [1:0] sz);
    case (sz)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  // Byte offset inside the word once the bits below the access size are dropped.
  function automatic logic [1:0] align_offset(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return off;
      SZ_H:    return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if
// Data-memory bus between the LSU (master) and the memory/interconnect (slave).
//   bus_req    master->slave  request strobe, held until bus_gnt
//   bus_we     master->slave  1 = write
//   bus_addr   master->slave  word-aligned address
//   bus_be     master->slave  byte enables, one per lane
//   bus_wdata  master->slave  lane-replicated store data
//   bus_gnt    slave->master  request accepted this cycle
//   bus_rvalid slave->master  read data valid
//   bus_rdata  slave->master  read data (whole word)
// -----------------------------------------------------------------------------
interface lsu_if #(
  parameter int WordSize = 32
);
  logic                bus_req;
  logic                bus_we;
  logic [WordSize-1:0] bus_addr;
  logic [3:0]          bus_be;
  logic [WordSize-1:0] bus_wdata;
  logic                bus_gnt;
  logic                bus_rvalid;
  logic [WordSize-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane steering for the LSU.
//   Store side: st_size/st_off/st_data -> st_be (byte enables) and st_lanes
//               (store data replicated across every lane of its size).
//   Load side : ld_rdata shifted down by ld_off bytes, truncated to ld_size and
//               zero- or sign-extended (ld_unsigned) -> ld_data.
// Lane logic is fixed at four byte lanes, so WordSize must be 32.
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  size_e               st_size,
  input  logic [1:0]          st_off,
  input  logic [WordSize-1:0] st_data,
  output logic [3:0]          st_be,
  output logic [WordSize-1:0] st_lanes,
  input  size_e               ld_size,
  input  logic [1:0]          ld_off,
  input  logic                ld_unsigned,
  input  logic [WordSize-1:0] ld_rdata,
  output logic [WordSize-1:0] ld_data
);

  function automatic logic [WordSize-1:0] extend_byte(input logic [7:0] b, input logic uns);
    return uns ? {{(WordSize-8){1'b0}}, b} : {{(WordSize-8){b[7]}}, b};
  endfunction

  function automatic logic [WordSize-1:0] extend_half(input logic [15:0] h, input logic uns);
    return uns ? {{(WordSize-16){1'b0}}, h} : {{(WordSize-16){h[15]}}, h};
  endfunction

  logic [WordSize-1:0] ld_shifted;

  always_comb begin
    st_be    = 4'b1111;
    st_lanes = st_data;
    case (st_size)
      SZ_B: begin
        st_be    = 4'b0001 << st_off;
        st_lanes = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_be    = 4'b0011 << st_off;
        st_lanes = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed byte down to lane 0 before truncating.
  assign ld_shifted = ld_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = ld_shifted;
    case (ld_size)
      SZ_B:    ld_data = extend_byte(ld_shifted[7:0], ld_unsigned);
      SZ_H:    ld_data = extend_half(ld_shifted[15:0], ld_unsigned);
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// Load/store unit sitting behind the EX/MEM register. Captures one memory op,
// runs it on the data bus and returns load results as a one-cycle write-back.
//   clk, rst      clock; asynchronous active-high reset
//   req_*, addr,  memory op from EX/MEM (valid, store flag, size, unsigned load,
//   wdata, rdn_in effective address, store data, load destination register)
//   stall         holds EX/MEM and earlier stages while the op is in flight
//   bus           lsu_if master: request/grant write-or-read, then rvalid data
//   wb_valid,     one-cycle load result pulse with destination and data;
//   wb_rdn,       wb_rdn/wb_data hold their last value between pulses
//   wb_data
//   misalign      one-cycle pulse for a trapped misaligned access
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently forcing them aligned (misalign tied 0 otherwise).
// FSM: IDLE -> REQ -> (WAIT for loads) -> DONE -> IDLE; a trapped access goes
// IDLE -> DONE so that stall drops and EX/MEM can move on.
// -----------------------------------------------------------------------------
module lsu
  import lsu_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [WordSize-1:0] addr,
  input  logic [WordSize-1:0] wdata,
  input  logic [4:0]          rdn_in,
  output logic                stall,
  lsu_if.master               bus,
  output logic                wb_valid,
  output logic [4:0]          wb_rdn,
  output logic [WordSize-1:0] wb_data,
  output logic                misalign
);

  state_e state_q, state_d;

  size_e               req_sz;
  logic [1:0]          req_off;
  logic                accept;
  logic                trap;
  logic                trap_q;

  // Captured op (datapath only, no reset needed: read only after a capture).
  logic                op_we_q;
  size_e               op_size_q;
  logic                op_uns_q;
  logic [1:0]          op_off_q;
  logic [4:0]          op_rdn_q;

  logic                bus_we_q;
  logic [WordSize-1:0] bus_addr_q;
  logic [3:0]          bus_be_q;
  logic [WordSize-1:0] bus_wdata_q;

  logic [3:0]          st_be;
  logic [WordSize-1:0] st_lanes;
  logic [WordSize-1:0] ld_data;

  assign req_sz  = decode_size(req_size);
  assign req_off = align_offset(req_sz, addr[1:0]);
  assign accept  = (state_q == IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap     = accept && is_misaligned(req_sz, addr[1:0]);
  assign misalign = trap_q && (state_q == DONE);
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  lsu_align #(
    .WordSize (WordSize)
  ) u_align (
    .st_size     (req_sz),
    .st_off      (req_off),
    .st_data     (wdata),
    .st_be       (st_be),
    .st_lanes    (st_lanes),
    .ld_size     (op_size_q),
    .ld_off      (op_off_q),
    .ld_unsigned (op_uns_q),
    .ld_rdata    (bus.bus_rdata),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)             state_d = trap ? DONE : REQ;
      REQ:  if (bus.bus_gnt)        state_d = op_we_q ? DONE : WAIT;
      WAIT: if (bus.bus_rvalid)     state_d = DONE;
      DONE:                         state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  assign stall    = accept || (state_q == REQ) || (state_q == WAIT);
  assign wb_valid = (state_q == DONE) && !op_we_q && !trap_q;

  assign bus.bus_req   = (state_q == REQ);
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

  // ---- op capture (IDLE -> REQ/DONE) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_we_q   <= req_we;
      op_size_q <= req_sz;
      op_uns_q  <= req_unsigned;
      op_off_q  <= req_off;
      op_rdn_q  <= rdn_in;
    end
  end

  // ---- control, bus drive and write-back registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      trap_q      <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= '0;
      wb_rdn      <= 5'd0;
      wb_data     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        trap_q <= trap;
        // Bus fields are loaded once here and stay put for the whole REQ phase.
        if (!trap) begin
          bus_we_q    <= req_we;
          bus_addr_q  <= {addr[WordSize-1:2], 2'b00};
          bus_be_q    <= st_be;
          bus_wdata_q <= st_lanes;
        end
      end
      if ((state_q == WAIT) && bus.bus_rvalid) begin
        wb_data <= ld_data;
        wb_rdn  <= op_rdn_q;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [4:0]  rdn_in = 5'd0;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rdn;
  logic [31:0] wb_data;
  logic        misalign;

  lsu_if #(.WordSize(32)) mem ();

  lsu #(.WordSize(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .rdn_in       (rdn_in),
    .stall        (stall),
    .bus          (mem),
    .wb_valid     (wb_valid),
    .wb_rdn       (wb_rdn),
    .wb_data      (wb_data),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Last write-back values seen by the reference model.
  logic [31:0] m_wb_data = 32'd0;
  logic [4:0]  m_wb_rdn  = 5'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int unsigned acc_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Offset used on the bus: address modulo 4, rounded down to the access size.
  function automatic int unsigned eff_off(input logic [1:0] sz, input logic [31:0] a);
    int unsigned n = acc_bytes(sz);
    return ((a % 4) / n) * n;
  endfunction

  function automatic logic [31:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
    int unsigned n = acc_bytes(sz);
    int unsigned be = ((1 << n) - 1) << eff_off(sz, a);
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
    int unsigned n = acc_bytes(sz);
    if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
    int unsigned n = acc_bytes(sz);
    int unsigned v = rd >> (8 * eff_off(sz, a));
    int unsigned mask;
    if (n == 4) return v;
    mask = (1 << (8 * n)) - 1;
    v = v & mask;
    if (!uns && (((v >> (8 * n - 1)) & 1) == 1)) v = v | ~mask;
    return v;
  endfunction

  // One complete op from the IDLE cycle through the cycle after DONE.
  // Entered and left 1 time unit after a rising edge, with the DUT in IDLE.
  task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input int gdly, input int rdly, input logic [31:0] rdat);
    logic [31:0] e_addr, e_be, e_wd, e_ld;
    e_addr = (a / 4) * 4;
    e_be   = ref_be(sz, a);
    e_wd   = ref_wdata(sz, wd);
    e_ld   = ref_load(sz, uns, a, rdat);

    mem.bus_rvalid = 1'b0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    addr = a; wdata = wd; rdn_in = rd;
    #1;
    check_eq("idle_stall", 32'(stall), 32'd1);
    check_eq("idle_req", 32'(mem.bus_req), 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k <= gdly; k++) begin
      mem.bus_gnt = (k == gdly);
      #1;
      check_eq("req_strobe", 32'(mem.bus_req), 32'd1);
      check_eq("req_addr", mem.bus_addr, e_addr);
      check_eq("req_be", 32'(mem.bus_be), e_be);
      check_eq("req_wdata", mem.bus_wdata, e_wd);
      check_eq("req_we", 32'(mem.bus_we), 32'(we));
      check_eq("req_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
    end
    mem.bus_gnt = 1'b0;

    if (!we) begin
      for (int k = 0; k <= rdly; k++) begin
        mem.bus_rvalid = (k == rdly);
        mem.bus_rdata  = (k == rdly) ? rdat : $urandom;
        #1;
        check_eq("wait_stall", 32'(stall), 32'd1);
        check_eq("wait_noreq", 32'(mem.bus_req), 32'd0);
        check_eq("wait_nowb", 32'(wb_valid), 32'd0);
        @(posedge clk); #1;
      end
      mem.bus_rvalid = 1'b0;
    end

    // DONE cycle
    #1;
    check_eq("done_wbvalid", 32'(wb_valid), 32'(!we));
    check_eq("done_stall", 32'(stall), 32'd0);
    check_eq("done_misalign", 32'(misalign), 32'd0);
    if (!we) begin
      m_wb_data = e_ld;
      m_wb_rdn  = rd;
    end
    check_eq("done_wbdata", wb_data, m_wb_data);
    check_eq("done_wbrdn", 32'(wb_rdn), 32'(m_wb_rdn));
    @(posedge clk); #1;

    // Back in IDLE: a stray rvalid must not disturb the held write-back.
    req_valid = 1'b0;
    mem.bus_rvalid = 1'b1;
    mem.bus_rdata  = $urandom;
    #1;
    check_eq("post_wbvalid", 32'(wb_valid), 32'd0);
    check_eq("post_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem.bus_rvalid = 1'b0;
    check_eq("post_hold_data", wb_data, m_wb_data);
    check_eq("post_hold_rdn", 32'(wb_rdn), 32'(m_wb_rdn));
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  task automatic trap_op(input logic we, input logic [1:0] sz, input logic [31:0] a);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = 1'b0;
    addr = a; wdata = $urandom; rdn_in = 5'd9;
    #1;
    check_eq("trap_idle_stall", 32'(stall), 32'd1);
    check_eq("trap_idle_req", 32'(mem.bus_req), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    check_eq("trap_pulse", 32'(misalign), 32'd1);
    check_eq("trap_noreq", 32'(mem.bus_req), 32'd0);
    check_eq("trap_nowb", 32'(wb_valid), 32'd0);
    check_eq("trap_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    check_eq("trap_pulse_end", 32'(misalign), 32'd0);
    check_eq("trap_noreq2", 32'(mem.bus_req), 32'd0);
    check_eq("trap_hold", wb_data, m_wb_data);
  endtask
`endif

  initial begin
    logic [1:0]  r_sz;
    logic [31:0] r_a;

    mem.bus_gnt = 1'b0;
    mem.bus_rvalid = 1'b0;
    mem.bus_rdata = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busreq", 32'(mem.bus_req), 32'd0);
    check_eq("rst_buswe", 32'(mem.bus_we), 32'd0);
    check_eq("rst_busaddr", mem.bus_addr, 32'd0);
    check_eq("rst_busbe", 32'(mem.bus_be), 32'd0);
    check_eq("rst_buswdata", mem.bus_wdata, 32'd0);
    check_eq("rst_wbvalid", 32'(wb_valid), 32'd0);
    check_eq("rst_wbrdn", 32'(wb_rdn), 32'd0);
    check_eq("rst_wbdata", wb_data, 32'd0);
    check_eq("rst_misalign", 32'(misalign), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store, grant on first REQ cycle
    run_op(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'd0);
    check_eq("sw_busaddr", mem.bus_addr, 32'h100);
    check_eq("sw_busbe", 32'(mem.bus_be), 32'hF);
    check_eq("sw_buswdata", mem.bus_wdata, 32'hDEAD_BEEF);

    // Signed byte load from the top lane
    run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 5'd5, 0, 1, 32'h80FF_FFFF);
    check_eq("lb_data", wb_data, 32'hFFFF_FF80);
    check_eq("lb_rdn", 32'(wb_rdn), 32'd5);

    // Unsigned half load, grant delayed three cycles
    run_op(1'b0, 2'b01, 1'b1, 32'h102, 32'd0, 5'd12, 3, 2, 32'h8001_0000);
    check_eq("lhu_data", wb_data, 32'h0000_8001);

    // Load to x0 still runs the bus and pulses write-back
    run_op(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 5'd0, 1, 0, 32'h1234_5678);
    check_eq("lw_x0_data", wb_data, 32'h1234_5678);

    // Byte and half stores on each lane / size 2'b11 as word
    run_op(1'b1, 2'b00, 1'b0, 32'h202, 32'hAABB_CC5A, 5'd0, 2, 0, 32'd0);
    check_eq("sb_be", 32'(mem.bus_be), 32'h4);
    check_eq("sb_wdata", mem.bus_wdata, 32'h5A5A_5A5A);
    run_op(1'b1, 2'b11, 1'b0, 32'h300, 32'h0BAD_F00D, 5'd0, 0, 0, 32'd0);
    check_eq("s11_be", 32'(mem.bus_be), 32'hF);

    // Reset while waiting for read data
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    addr = 32'h500; rdn_in = 5'd3;
    @(posedge clk); #1;
    mem.bus_gnt = 1'b1;
    @(posedge clk); #1;
    mem.bus_gnt = 1'b0;
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    check_eq("mid_rst_busreq", 32'(mem.bus_req), 32'd0);
    check_eq("mid_rst_stall", 32'(stall), 32'd0);
    check_eq("mid_rst_busaddr", mem.bus_addr, 32'd0);
    check_eq("mid_rst_wbdata", wb_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem.bus_rvalid = 1'b1;
    mem.bus_rdata  = 32'hCAFE_0001;
    #1;
    check_eq("after_rst_wbvalid", 32'(wb_valid), 32'd0);
    check_eq("after_rst_busreq", 32'(mem.bus_req), 32'd0);
    check_eq("after_rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem.bus_rvalid = 1'b0;
    #1;
    check_eq("after_rvalid_wbvalid", 32'(wb_valid), 32'd0);
    check_eq("after_rvalid_stall", 32'(stall), 32'd0);
    check_eq("after_rvalid_wbdata", wb_data, 32'd0);
    m_wb_data = 32'd0;
    m_wb_rdn  = 5'd0;
    @(posedge clk); #1;

    // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    trap_op(1'b0, 2'b10, 32'h101);
    trap_op(1'b1, 2'b01, 32'h103);
    run_op(1'b0, 2'b01, 1'b0, 32'h102, 32'd0, 5'd8, 0, 0, 32'hF00F_0000);
`else
    run_op(1'b0, 2'b10, 1'b0, 32'h101, 32'd0, 5'd7, 1, 1, 32'h0102_0304);
    check_eq("unal_busaddr", mem.bus_addr, 32'h100);
    check_eq("unal_busbe", 32'(mem.bus_be), 32'hF);
    check_eq("unal_data", wb_data, 32'h0102_0304);
    check_eq("unal_misalign", 32'(misalign), 32'd0);
`endif

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      r_sz = 2'($urandom_range(0, 3));
      r_a  = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
      r_a  = (r_a / acc_bytes(r_sz)) * acc_bytes(r_sz);
`endif
      run_op(1'($urandom_range(0, 1)), r_sz, 1'($urandom_range(0, 1)), r_a, $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter WordSize, default 32, data/address width; only 32 SHALL be supported (byte-lane logic assumes 4 lanes).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  memory op present in the EX/MEM register this cycle.
REQ-005 req_we  in  1  1 = store, 0 = load.
REQ-006 req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-008 addr  in  WordSize  effective address (ALU result); wdata  in  WordSize  store data (rs2 value).
REQ-009 rdn_in  in  5  destination register of the load.
REQ-010 stall  out  1  holds the EX/MEM register and earlier stages.
REQ-011 bus_req, bus_we  out  1  request strobe and write flag; bus_addr  out  WordSize  word-aligned address.
REQ-012 bus_be  out  4  byte enables; bus_wdata  out  WordSize  lane-replicated store data.
REQ-013 bus_gnt  in  1  request accepted; bus_rvalid  in  1  read data valid; bus_rdata  in  WordSize.
REQ-014 wb_valid  out  1  one-cycle load-result pulse; wb_rdn  out  5; wb_data  out  WordSize.
REQ-015 misalign  out  1  one-cycle misaligned-access pulse.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-017 IDLE: req_valid=1 SHALL register op, address, lane data and rdn_in, and go to REQ.
REQ-018 REQ: bus_req=1 with bus_addr/we/be/wdata held stable until bus_gnt; on gnt, store -> DONE, load -> WAIT.
REQ-019 bus_gnt in the same cycle bus_req first rises SHALL be accepted (minimum store latency 3 cycles, IDLE->REQ->DONE).
REQ-020 WAIT: bus_rvalid=1 SHALL capture aligned/extended data into wb_data and go to DONE; bus_rvalid in any other state SHALL be ignored.
REQ-021 DONE: wb_valid=1 for loads only, with wb_rdn from the captured rdn; next state IDLE unconditionally.
REQ-022 stall SHALL equal (IDLE and req_valid) or state in {REQ, WAIT}; stall=0 in DONE so EX/MEM advances on that edge.
REQ-023 bus_addr SHALL be {addr[31:2], 2'b00}; bus_be = 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word).
REQ-024 bus_wdata SHALL be {4{wdata[7:0]}} byte, {2{wdata[15:0]}} half, wdata word.
REQ-025 Load data SHALL be bus_rdata >> (8*addr[1:0]), then truncated to size and sign/zero-extended per req_unsigned.
REQ-026 wb_data and wb_rdn SHALL hold their last value outside DONE; wb_valid=0 outside DONE.
REQ-027 rdn_in=0 loads SHALL still perform the bus access and pulse wb_valid.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE and bus_req, bus_we, bus_be, bus_addr, bus_wdata, wb_valid, wb_rdn, wb_data, misalign to 0; stall follows REQ-022.
REQ-029 rst mid-operation SHALL abandon the transaction with no wb_valid; a bus_rvalid arriving after reset SHALL be ignored.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 in IDLE SHALL pulse misalign next cycle, issue no bus request, no wb_valid, and return to IDLE (stall high one cycle).
REQ-031 Macro undefined: misalign SHALL be tied 0 and addr bits below access size ignored (forced aligned).

Structure
REQ-032 Package lsu_pkg SHALL hold the size encoding enum (SZ_B, SZ_H, SZ_W) and the FSM state enum.
REQ-033 One combinational sub-module lsu_align SHALL compute bus_be, bus_wdata and load extraction/extension.

Verification
REQ-034 Word store addr=0x100, wdata=0xDEADBEEF, gnt on first REQ cycle -> bus_be=1111, bus_wdata=0xDEADBEEF, stall 2 cycles, no wb_valid.
REQ-035 Byte load signed addr=0x103, rdata=0x80FFFFFF, rdn_in=5 -> wb_data=0xFFFFFF80, wb_rdn=5, wb_valid 1 cycle.
REQ-036 Half load unsigned addr=0x102, rdata=0x8001_0000 -> wb_data=0x00008001; gnt delayed 3 cycles -> bus signals stable throughout REQ.
REQ-037 rst pulse while in WAIT, then bus_rvalid=1 -> no wb_valid, state IDLE, bus_req=0.
REQ-038 LSU_MISALIGN_TRAP_EN set, word load addr=0x101 -> misalign pulse, bus_req never asserted; undefined -> bus_addr=0x100, bus_be=1111.
